// File: rtl/trolley_system_led_pio.sv
// Avalon-MM output PIO with atomic bit set/clear and a shared-phase hardware
// blink on selected lines, timed by a programmable half-period prescaler.
module trolley_system_led_pio #(
  parameter int unsigned           WIDTH     = 8,
  parameter int unsigned           PERIOD_W  = 24,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_BLINK  = 3'd3;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  logic [WIDTH-1:0]    data_q,   data_d;
  logic [WIDTH-1:0]    blink_q,  blink_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q,    cnt_d;
  logic                phase_q,  phase_d;

  logic                wr_en;
  logic [WIDTH-1:0]    wd_bits;
  logic [PERIOD_W-1:0] wd_period;

  assign wr_en     = chipselect & ~write_n;
  assign wd_bits   = writedata[WIDTH-1:0];
  assign wd_period = writedata[PERIOD_W-1:0];

  always_comb begin
    // NOTE: every next-state value is defaulted to hold first, so no branch
    // below can leave a signal unassigned and infer a latch.
    data_d   = data_q;
    blink_d  = blink_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;

    if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == period_q - PERIOD_W'(1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + PERIOD_W'(1);
    end

    if (wr_en) begin
      unique case (address)
        ADDR_DATA:   data_d  = wd_bits;
        ADDR_SET:    data_d  = data_q | wd_bits;
        ADDR_CLEAR:  data_d  = data_q & ~wd_bits;
        ADDR_BLINK:  blink_d = wd_bits;
        // A new period restarts the prescaler and wins over a coincident wrap.
        ADDR_PERIOD: begin
          period_d = wd_period;
          cnt_d    = '0;
          phase_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so all flops update
    // together from values sampled before the edge.
    if (!reset_n) begin
      data_q   <= RESET_VAL;
      blink_q  <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
    end else begin
      data_q   <= data_d;
      blink_q  <= blink_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

  // Blink can only mask a line off; it never drives a cleared bit high.
  assign out_port = data_q & ~(blink_q & {WIDTH{~phase_q}});

  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_DATA, ADDR_SET, ADDR_CLEAR: readdata[WIDTH-1:0]    = data_q;
      ADDR_BLINK:                      readdata[WIDTH-1:0]    = blink_q;
      ADDR_PERIOD:                     readdata[PERIOD_W-1:0] = period_q;
      ADDR_STATUS:                     readdata[0]            = phase_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trolley_system_led_pio.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized bus phase, all compared every cycle against a behavioural model.
module tb_trolley_system_led_pio;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  trolley_system_led_pio dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  // Model: registers plus the number of edges since the prescaler last restarted.
  logic [7:0]  m_data, m_blink;
  logic [23:0] m_period;
  int          m_t;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data = 8'h00; m_blink = 8'h00; m_period = 24'd0; m_t = 0;
    end else begin
      m_t = m_t + 1;
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data  = writedata[7:0];
          3'd1: m_data  = m_data | writedata[7:0];
          3'd2: m_data  = m_data & ~writedata[7:0];
          3'd3: m_blink = writedata[7:0];
          3'd4: begin m_period = writedata[23:0]; m_t = 0; end
          default: ;
        endcase
      end
    end
  end

  function automatic logic exp_phase();
    if (m_period == 0) return 1'b1;
    return ((m_t / int'(m_period)) % 2) == 0;
  endfunction

  function automatic logic [7:0] exp_out();
    return exp_phase() ? m_data : (m_data & ~m_blink);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] a);
    case (a)
      3'd0, 3'd1, 3'd2: return {24'd0, m_data};
      3'd3:             return {24'd0, m_blink};
      3'd4:             return {8'd0, m_period};
      3'd5:             return {31'd0, exp_phase()};
      default:          return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_out", {24'd0, out_port}, {24'd0, exp_out()});
      check("cyc_rd", readdata, exp_rd(address));
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #2;
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic peek(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a; #1;
    check(name, readdata, exp);
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_during", {24'd0, out_port}, 32'h00);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    peek("rst_data", 3'd0, 32'h00);
    check("rst_out", {24'd0, out_port}, 32'h00);
    peek("rst_status", 3'd5, 32'h1);

    bus_write(3'd0, 32'hFFFF_FFA5);
    check("wr_data_out", {24'd0, out_port}, 32'hA5);
    bus_write(3'd1, 32'h0000_000F);
    check("set_out", {24'd0, out_port}, 32'hAF);
    bus_write(3'd2, 32'h0000_0081);
    check("clear_out", {24'd0, out_port}, 32'h2E);
    peek("clear_rd", 3'd0, 32'h2E);

    bus_write(3'd0, 32'hFF);
    bus_write(3'd3, 32'h0F);
    bus_write(3'd4, 32'd4);
    address = 3'd5;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("blink4_out", {24'd0, out_port}, (i < 4) ? 32'hFF : 32'hF0);
      check("blink4_status", readdata, (i < 4) ? 32'h1 : 32'h0);
    end

    bus_write(3'd4, 32'd3);
    address = 3'd5;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("blink3_out", {24'd0, out_port}, (i < 3) ? 32'hFF : 32'hF0);
    end

    bus_write(3'd4, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("frozen_out", {24'd0, out_port}, 32'hFF);
    end

    bus_write(3'd4, 32'd2);
    address = 3'd5;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (readdata[0] == 1'b0) seen = 1'b1;
    end
    check("phase0_reached", {31'd0, seen}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_out", {24'd0, out_port}, 32'h00);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    peek("post_rst_data", 3'd0, 32'h0);
    peek("post_rst_blink", 3'd3, 32'h0);
    peek("post_rst_period", 3'd4, 32'h0);
    peek("post_rst_status", 3'd5, 32'h1);

    bus_write(3'd0, 32'h3C);
    bus_write(3'd3, 32'h05);
    bus_write(3'd4, 32'd7);
    for (int a = 5; a < 8; a++) bus_write(3'(a), 32'hFFFF_FFFF);
    peek("ign_data", 3'd0, 32'h3C);
    peek("ign_blink", 3'd3, 32'h05);
    peek("ign_period", 3'd4, 32'd7);
    peek("ign_rd6", 3'd6, 32'h0);
    peek("ign_rd7", 3'd7, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 2) != 0);
      address    = 3'($urandom_range(0, 7));
      writedata  = $urandom;
      if (address == 3'd4) writedata = $urandom_range(0, 6);
    end
    @(posedge clk); #2;
    chipselect = 1'b0; write_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
